// File: rtl/text_periph_uart.sv
// Memory-mapped transmit-only UART: 16-byte register window, TX FIFO, 8N1 serializer and
// a level "TX FIFO empty" interrupt.
module text_periph_uart #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic        i_cpu_clk,
    input  logic        i_rst,
    input  logic        i_bus_clk,
    input  logic        i_bus_we,
    input  logic [31:0] i_bus_addr,
    input  logic [31:0] i_bus_data,
    output logic [31:0] o_bus_data,
    output logic        o_bus_data_ready,
    output logic        o_tx,
    output logic        o_irq
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0]        COUNT_MAX = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_t;

    // Bus front end
    logic        bus_clk_prev;
    logic        req;
    logic        hit;
    logic [1:0]  reg_sel;
    logic        wr_data;
    logic        wr_ctrl;
    logic        rd_status;
    logic [31:0] rd_data;

    // Control / status
    logic enable;
    logic irq_en;
    logic overflow;
    logic flush;

    // FIFO
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [4:0]       count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Serializer
    tx_state_t         state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic              tx_busy;

    // Address bits [1:0] and the upper write-data bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{i_bus_addr[1:0], i_bus_data[31:8]};

    assign req       = i_bus_clk & ~bus_clk_prev;
    assign hit       = req & (i_bus_addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel   = i_bus_addr[3:2];
    assign wr_data   = hit & i_bus_we & (reg_sel == 2'd0);
    assign wr_ctrl   = hit & i_bus_we & (reg_sel == 2'd2);
    assign rd_status = hit & ~i_bus_we & (reg_sel == 2'd1);
    assign flush     = wr_ctrl & i_bus_data[2];

    assign full    = (count == COUNT_MAX);
    assign empty   = (count == 5'd0);
    assign tx_busy = (state != StIdle);
    // A full FIFO refuses the push even if the serializer pops in the same cycle.
    assign push    = wr_data & ~full;
    assign pop     = (state == StIdle) & enable & ~empty & ~flush;

    // Read-data mux; writes and register 3 return zero.
    always_comb begin
        rd_data = 32'd0;
        if (!i_bus_we) begin
            case (reg_sel)
                2'd1:    rd_data = {19'd0, count, 4'd0, overflow, tx_busy, empty, full};
                2'd2:    rd_data = {29'd0, 1'b0, irq_en, enable};
                default: rd_data = 32'd0;
            endcase
        end
    end

    // Bus handshake, CTRL register and sticky overflow flag.
    always_ff @(posedge i_cpu_clk or posedge i_rst) begin
        if (i_rst) begin
            bus_clk_prev     <= 1'b1;
            o_bus_data       <= 32'd0;
            o_bus_data_ready <= 1'b0;
            enable           <= 1'b0;
            irq_en           <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            bus_clk_prev     <= i_bus_clk;
            o_bus_data_ready <= hit;
            if (hit) begin
                o_bus_data <= rd_data;
            end
            if (wr_ctrl) begin
                enable <= i_bus_data[0];
                irq_en <= i_bus_data[1];
            end
            if (wr_data && full) begin
                overflow <= 1'b1;
            end else if (rd_status) begin
                overflow <= 1'b0;
            end
        end
    end

    // FIFO storage needs no reset; validity is tracked by the count.
    always_ff @(posedge i_cpu_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= i_bus_data[7:0];
        end
    end

    // FIFO pointers and occupancy; flush wins over everything else.
    always_ff @(posedge i_cpu_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 5'd0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 5'd0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + 5'd1;
            end else if (pop && !push) begin
                count <= count - 5'd1;
            end
        end
    end

    // 8N1 serializer; o_tx is registered and changes together with the state.
    always_ff @(posedge i_cpu_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= StIdle;
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            shift    <= 8'd0;
            o_tx     <= 1'b1;
        end else begin
            case (state)
                StIdle: begin
                    o_tx <= 1'b1;
                    if (pop) begin
                        state    <= StStart;
                        shift    <= fifo_mem[rd_ptr];
                        baud_cnt <= '0;
                        o_tx     <= 1'b0;
                    end
                end
                StStart: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= 3'd0;
                        state    <= StData;
                        o_tx     <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                StData: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= StStop;
                            o_tx  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            o_tx    <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                StStop: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= StIdle;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Registered "TX FIFO empty" interrupt.
    always_ff @(posedge i_cpu_clk or posedge i_rst) begin
        if (i_rst) begin
            o_irq <= 1'b0;
        end else begin
            o_irq <= irq_en & enable & empty & ~tx_busy;
        end
    end

endmodule
